line_window_reader: RTL

LINE_WINDOW_READER -- requirements
Module: line_window_reader

---
 rtl/line_window_reader_pkg.sv | 10 +
 rtl/line_window_reader_line_delay.sv | 31 +++
 rtl/line_window_reader.sv | 82 ++++++++
 3 files changed

// File: rtl/line_window_reader_pkg.sv
// line_window_reader_pkg: shared state encoding and default geometry for the 3x3 window reader
package line_window_reader_pkg;

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    localparam int DEF_DATA_W       = 8;
    localparam int DEF_LINE_WIDTH   = 16;
    localparam int DEF_FRAME_HEIGHT = 16;

endpackage

// File: rtl/line_window_reader_line_delay.sv
// line_delay: DEPTH-cell shift register advanced only on accepted pixels
//   CLK      - clock
//   Reset_n  - async active-low reset, clears every cell
//   Enable   - shift qualifier
//   DataIn   - pixel entering the delay
//   DataOut  - pixel accepted DEPTH shifts earlier
module line_delay #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              CLK,
    input  logic              Reset_n,
    input  logic              Enable,
    input  logic [DATA_W-1:0] DataIn,
    output logic [DATA_W-1:0] DataOut
);

    logic [DATA_W-1:0] cell_q [DEPTH];

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) cell_q[i] <= '0;
        end else if (Enable) begin
            cell_q[0] <= DataIn;
            for (int i = 1; i < DEPTH; i++) cell_q[i] <= cell_q[i-1];
        end
    end

    assign DataOut = cell_q[DEPTH-1];

endmodule

// File: rtl/line_window_reader.sv
// line_window_reader: builds a 3x3 pixel neighbourhood from a raster stream
//   CLK         - clock
//   Reset_n     - async active-low reset
//   Enable      - DataIn valid qualifier
//   DataIn      - raster-order pixels
//   Window      - 3x3 neighbourhood, P00 in the MSBs, P22 (newest) in the LSBs
//   WindowValid - Window is a complete in-frame neighbourhood
//   FrameDone   - one-cycle pulse after the last pixel of a frame
module line_window_reader
    import line_window_reader_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int LINE_WIDTH   = DEF_LINE_WIDTH,
    parameter int FRAME_HEIGHT = DEF_FRAME_HEIGHT
) (
    input  logic                CLK,
    input  logic                Reset_n,
    input  logic                Enable,
    input  logic [DATA_W-1:0]   DataIn,
    output logic [9*DATA_W-1:0] Window,
    output logic                WindowValid,
    output logic                FrameDone
);

    localparam int CW = $clog2(LINE_WIDTH);
    localparam int RW = $clog2(FRAME_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(LINE_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_HEIGHT - 1);

    state_t                  state_q, state_d;
    logic [CW-1:0]           col_q, col_d;
    logic [RW-1:0]           row_q, row_d;
    logic [8:0][DATA_W-1:0]  win_q, win_d;
    logic [DATA_W-1:0]       tap1, tap2;
    logic                    valid_q, done_q, col_wrap, last_px;

    line_delay #(.DATA_W(DATA_W), .DEPTH(LINE_WIDTH)) u_ld1 (
        .CLK(CLK), .Reset_n(Reset_n), .Enable(Enable), .DataIn(DataIn), .DataOut(tap1)
    );

    line_delay #(.DATA_W(DATA_W), .DEPTH(LINE_WIDTH)) u_ld2 (
        .CLK(CLK), .Reset_n(Reset_n), .Enable(Enable), .DataIn(tap1), .DataOut(tap2)
    );

    // Window index 8 is P00, index 0 is P22; each row shifts left and takes its new column
    always_comb begin
        col_wrap = col_q == COL_LAST;
        last_px  = col_wrap && row_q == ROW_LAST;
        col_d    = col_wrap ? '0 : col_q + CW'(1);
        row_d    = last_px ? '0 : col_wrap ? row_q + RW'(1) : row_q;
        state_d  = state_q == IDLE ? FILL :
                   (state_q == FILL && row_q == RW'(2) && col_q == '0) ? RUN :
                   (state_q == RUN && last_px) ? FILL : state_q;
        win_d    = {win_q[7:6], tap2, win_q[4:3], tap1, win_q[1:0], DataIn};
    end

    // Outputs are recomputed every cycle so an idle cycle always drops WindowValid
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            win_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            valid_q <= Enable && state_q == RUN && row_q >= RW'(2) && col_q >= CW'(2);
            done_q  <= Enable && last_px;
            if (Enable) begin
                state_q <= state_d;
                col_q   <= col_d;
                row_q   <= row_d;
                win_q   <= win_d;
            end
        end
    end

    assign Window      = win_q;
    assign WindowValid = valid_q;
    assign FrameDone   = done_q;

endmodule
